// File: rtl/mem_2r1w_be.sv
// Two-read, one-byte-masked-write memory with a post-reset hardware clear sweep.
// Optional write-first read bypass enabled by defining MEM_BYPASS_EN (default: read-first).
module mem_2r1w_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      rd_addr0,
    input  logic                   rd_en0,
    output logic [DATA_W-1:0]      rd_dout0,
    input  logic [ADDR_W-1:0]      rd_addr1,
    input  logic                   rd_en1,
    output logic [DATA_W-1:0]      rd_dout1,
    input  logic [ADDR_W-1:0]      wr_addr0,
    input  logic [DATA_W-1:0]      wr_din0,
    input  logic [DATA_W/8-1:0]    we0,
    output logic                   init_busy
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  clr_ptr_reg, clr_ptr_next;
    logic [DATA_W-1:0]  rd_dout0_reg, rd_dout1_reg;
    logic [DATA_W-1:0]  rd_word0, rd_word1;
    logic [NB-1:0]      lane_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               run;

    assign run = (state_reg == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        if (state_reg == CLEAR) begin
            clr_ptr_next = clr_ptr_reg + 1'b1;
            if (&clr_ptr_reg)
                state_next = RUN;
        end
    end

    // The sweep borrows the single write port; user writes are masked until RUN.
    always_comb begin
        lane_we   = '0;
        mem_waddr = wr_addr0;
        mem_wdata = wr_din0;
        if (!rst) begin
            if (state_reg == CLEAR) begin
                lane_we   = '1;
                mem_waddr = clr_ptr_reg;
                mem_wdata = '0;
            end else begin
                lane_we = we0;
            end
        end
    end

    // One narrow RAM per byte lane so each lane has a single clean write enable.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (lane_we[gi])
                lane_mem[mem_waddr] <= mem_wdata[gi*8 +: 8];
        end

`ifdef MEM_BYPASS_EN
        assign rd_word0[gi*8 +: 8] = (run && lane_we[gi] && (wr_addr0 == rd_addr0))
                                     ? wr_din0[gi*8 +: 8] : lane_mem[rd_addr0];
        assign rd_word1[gi*8 +: 8] = (run && lane_we[gi] && (wr_addr0 == rd_addr1))
                                     ? wr_din0[gi*8 +: 8] : lane_mem[rd_addr1];
`else
        assign rd_word0[gi*8 +: 8] = lane_mem[rd_addr0];
        assign rd_word1[gi*8 +: 8] = lane_mem[rd_addr1];
`endif
    end

    // CLEAR is only reachable through reset, so holding here keeps the outputs at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dout0_reg <= '0;
            rd_dout1_reg <= '0;
        end else begin
            if (run && rd_en0)
                rd_dout0_reg <= rd_word0;
            if (run && rd_en1)
                rd_dout1_reg <= rd_word1;
        end
    end

    assign rd_dout0  = rd_dout0_reg;
    assign rd_dout1  = rd_dout1_reg;
    assign init_busy = (state_reg == CLEAR);

endmodule

// File: tb/tb_mem_2r1w_be.sv
// Self-checking bench for mem_2r1w_be: directed vector table, reset/sweep sequences
// and randomized traffic against an array-based reference model.
module tb_mem_2r1w_be;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_addr0, rd_addr1, wr_addr0;
    logic        rd_en0, rd_en1;
    logic [31:0] rd_dout0, rd_dout1, wr_din0;
    logic [3:0]  we0;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [16];
    logic [31:0] model_q0, model_q1;

    typedef struct {
        logic [3:0]  we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        re0;
        logic [3:0]  ra0;
        logic        re1;
        logic [3:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [13];

    mem_2r1w_be #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr0  (rd_addr0),
        .rd_en0    (rd_en0),
        .rd_dout0  (rd_dout0),
        .rd_addr1  (rd_addr1),
        .rd_en1    (rd_en1),
        .rd_dout1  (rd_dout1),
        .wr_addr0  (wr_addr0),
        .wr_din0   (wr_din0),
        .we0       (we0),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
        model_q0 = 32'h0;
        model_q1 = 32'h0;
    endtask

    // One RUN-mode cycle: drive, update the reference model, advance one edge.
    task automatic drive_cycle(input logic [3:0] we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic re0, input logic [3:0] ra0,
                               input logic re1, input logic [3:0] ra1);
        logic [31:0] merged;
        we0 = we; wr_addr0 = wa; wr_din0 = wd;
        rd_en0 = re0; rd_addr0 = ra0; rd_en1 = re1; rd_addr1 = ra1;
        merged = model_mem[wa];
        for (int b = 0; b < 4; b++)
            if (we[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
`ifdef MEM_BYPASS_EN
        if (re0) model_q0 = (ra0 == wa) ? merged : model_mem[ra0];
        if (re1) model_q1 = (ra1 == wa) ? merged : model_mem[ra1];
`else
        if (re0) model_q0 = model_mem[ra0];
        if (re1) model_q1 = model_mem[ra1];
`endif
        model_mem[wa] = merged;
        tick();
        we0 = 4'h0; rd_en0 = 1'b0; rd_en1 = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (init_busy && n < 100);
    endtask

    initial begin
        int n;
        logic [31:0] rdw_exp, both_exp;
`ifdef MEM_BYPASS_EN
        rdw_exp  = 32'h0000_5678;
        both_exp = 32'hAABB_5678;
`else
        rdw_exp  = 32'h0000_00FF;
        both_exp = 32'h0000_5678;
`endif
        //          we     wa  wd            re0 ra0 re1 ra1 e0             e1
        vecs[0]  = '{4'hF, 5, 32'h11223344, 0, 0, 0, 0, 32'h0,         32'h0};
        vecs[1]  = '{4'h5, 5, 32'hAABBCCDD, 0, 0, 0, 0, 32'h0,         32'h0};
        vecs[2]  = '{4'h0, 0, 32'h0,        1, 5, 0, 0, 32'h11BB33DD,  32'h0};
        vecs[3]  = '{4'hF, 1, 32'h1,        0, 0, 0, 0, 32'h11BB33DD,  32'h0};
        vecs[4]  = '{4'hF, 2, 32'h2,        0, 0, 0, 0, 32'h11BB33DD,  32'h0};
        vecs[5]  = '{4'h0, 0, 32'h0,        1, 1, 1, 2, 32'h1,         32'h2};
        vecs[6]  = '{4'h0, 0, 32'h0,        0, 9, 0, 4, 32'h1,         32'h2};
        vecs[7]  = '{4'h0, 0, 32'h0,        0, 2, 0, 1, 32'h1,         32'h2};
        vecs[8]  = '{4'hF, 7, 32'h000000FF, 0, 0, 0, 0, 32'h1,         32'h2};
        vecs[9]  = '{4'h3, 7, 32'h12345678, 1, 7, 0, 0, rdw_exp,       32'h2};
        vecs[10] = '{4'h0, 0, 32'h0,        1, 7, 1, 7, 32'h0000_5678, 32'h0000_5678};
        vecs[11] = '{4'hC, 7, 32'hAABBCCDD, 1, 7, 1, 7, both_exp,      both_exp};
        vecs[12] = '{4'h0, 0, 32'h0,        1, 7, 1, 7, 32'hAABB_5678, 32'hAABB_5678};

        rst = 1'b1;
        rd_addr0 = '0; rd_addr1 = '0; wr_addr0 = '0;
        rd_en0 = 1'b0; rd_en1 = 1'b0; wr_din0 = '0; we0 = '0;
        model_clear();

        // Reset state and first sweep with an ignored write on cycle 2.
        #2;
        chk("reset_dout0", rd_dout0, 32'h0);
        chk("reset_dout1", rd_dout1, 32'h0);
        chk("reset_busy", {31'h0, init_busy}, 32'h1);
        #28 rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                we0 = 4'hF; wr_addr0 = 4'd3; wr_din0 = 32'hDEADBEEF;
            end else if (n == 2) begin
                we0 = 4'h0;
            end
        end while (init_busy && n < 100);
        chk("init_busy_len", n, 16);
        drive_cycle(4'h0, 4'h0, 32'h0, 1'b1, 4'd3, 1'b0, 4'd0);
        chk("clear_ignores_write", rd_dout0, 32'h0);

        for (int i = 0; i < 13; i++) begin
            drive_cycle(vecs[i].we, vecs[i].wa, vecs[i].wd,
                        vecs[i].re0, vecs[i].ra0, vecs[i].re1, vecs[i].ra1);
            chk($sformatf("vec%0d_dout0", i), rd_dout0, vecs[i].e0);
            chk($sformatf("vec%0d_dout1", i), rd_dout1, vecs[i].e1);
        end

        // Reset in RUN with populated memory, then a second reset mid-sweep.
        for (int a = 0; a < 16; a++)
            drive_cycle(4'hF, 4'(a), 32'h01010101 * (a + 1), 1'b0, 4'd0, 1'b0, 4'd0);
        drive_cycle(4'h0, 4'h0, 32'h0, 1'b1, 4'd15, 1'b1, 4'd14);
        chk("pre_rst_dout0", rd_dout0, 32'h10101010);
        chk("pre_rst_dout1", rd_dout1, 32'h0F0F0F0F);
        rst = 1'b1;
        #1;
        chk("run_rst_dout0", rd_dout0, 32'h0);
        chk("run_rst_dout1", rd_dout1, 32'h0);
        chk("run_rst_busy", {31'h0, init_busy}, 32'h1);
        tick();
        rst = 1'b0;
        model_clear();
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("sweep_busy_c%0d", c + 1), {31'h0, init_busy}, 32'h1);
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_dout0", rd_dout0, 32'h0);
        chk("mid_rst_busy", {31'h0, init_busy}, 32'h1);
        tick();
        rst = 1'b0;
        count_busy(n);
        chk("resweep_busy_len", n, 16);
        for (int a = 0; a < 16; a++) begin
            drive_cycle(4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b1, 4'(15 - a));
            chk($sformatf("zero_a%0d_dout0", a), rd_dout0, 32'h0);
            chk($sformatf("zero_a%0d_dout1", a), rd_dout1, 32'h0);
        end

        // Randomized traffic with forced address collisions.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] we, wa, ra0, ra1;
            logic [31:0] wd;
            we  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            wa  = 4'($urandom_range(0, 15));
            wd  = $urandom;
            ra0 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            drive_cycle(we, wa, wd, 1'($urandom_range(0, 1)), ra0, 1'($urandom_range(0, 1)), ra1);
            chk($sformatf("rand%0d_dout0", i), rd_dout0, model_q0);
            chk($sformatf("rand%0d_dout1", i), rd_dout1, model_q1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_2r1w_be.md
Name: mem_2r1w_be

Overview:
- Parametrised successor to the single-read, single-write core memory.
- Provides two independent registered read ports and one byte-masked write port.
- After reset, a hardware clear sweep zeroes every word, so software and the pipeline never see X contents.
- Used as a register file or scratch data memory inside the RISC-V core; single clock domain.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; depth = 2**ADDR_W words.
- NB, DATA_W/8, derived byte-lane count (localparam, not overridable).

Ports:
- clk  in  1  system clock; rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr0  in  ADDR_W  read port 0 address.
- rd_en0  in  1  read port 0 enable.
- rd_dout0  out  DATA_W  read port 0 data, registered.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_en1  in  1  read port 1 enable.
- rd_dout1  out  DATA_W  read port 1 data, registered.
- wr_addr0  in  ADDR_W  write address.
- wr_din0  in  DATA_W  write data.
- we0  in  NB  per-byte write enable; bit i covers wr_din0[8i+7:8i].
- init_busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (async, rst=1):
  - rd_dout0=0, rd_dout1=0, init_busy=1.
  - FSM=CLEAR, clear pointer clr_ptr=0.
  - Array contents are not reset directly.
- FSM states:
  - CLEAR: each rising edge with rst=0 writes 0 to mem[clr_ptr], then clr_ptr++. When clr_ptr == 2**ADDR_W-1 is written, next state is RUN and init_busy falls at that same edge.
  - The sweep takes exactly 2**ADDR_W cycles after rst deasserts (16 at default).
  - RUN: normal operation. RUN is terminal; only rst returns the FSM to CLEAR.
- During CLEAR:
  - we0 is ignored.
  - rd_en0/rd_en1 are ignored; rd_dout0/rd_dout1 hold 0.
- Write (RUN):
  - At a rising edge, for each i with we0[i]=1, mem[wr_addr0] byte i <= wr_din0 byte i.
  - Bytes with we0[i]=0 are unchanged. we0=0 means no write.
- Read (RUN), latency 1:
  - At a rising edge with rd_enN=1, rd_doutN <= mem[rd_addrN].
  - With rd_enN=0, rd_doutN holds its previous value.
- Both read ports may address the same word in the same cycle; each returns identical data.
- Read-during-write to the same address: see Optional Feature. Different addresses never interact.
- Reset mid-sweep: the FSM restarts CLEAR from clr_ptr=0 and init_busy stays high. A full 2**ADDR_W-cycle sweep follows the new deassertion.
- Reset in RUN: memory is re-zeroed by a fresh sweep and outputs go to 0 immediately (async).
- Addresses are always in range (full power-of-two depth), so no bounds check is needed.

Optional Feature:
- Macro: MEM_BYPASS_EN.
- Defined (write-first): on a same-edge read and write to the same address, rd_doutN receives the merged word.
  - Byte i = wr_din0 byte i where we0[i]=1; otherwise the old mem byte.
  - Applies independently to both read ports.
- Undefined (read-first): rd_doutN receives the pre-write array contents. The new data is visible on the next read.

Test Plan:
1. Reset and clear:
   - Stimulus: rst=1 for 30 ns, release, then apply we0=4'hF, wr_addr0=3, wr_din0=32'hDEADBEEF on cycle 2 after release.
   - Required: init_busy=1 for exactly 16 cycles; the write is ignored; after init_busy falls, reading addr 3 returns 32'h0.
2. Byte-masked write:
   - Stimulus (RUN): write 32'h11223344 with we0=4'hF to addr 5, then 32'hAABBCCDD with we0=4'b0101 to addr 5, then read port 0 at addr 5.
   - Required: rd_dout0=32'h11BB33DD one cycle after rd_en0.
3. Dual read and hold:
   - Stimulus: addr 1=32'h1, addr 2=32'h2; rd_addr0=1, rd_addr1=2, rd_en0=rd_en1=1 for one cycle, then rd_en deasserted and addresses changed.
   - Required: rd_dout0=1, rd_dout1=2 after one cycle, and both outputs hold those values while rd_en=0.
4. Read-during-write:
   - Stimulus: addr 7=32'h0000_00FF; same edge: write 32'h1234_5678 with we0=4'b0011 to addr 7, with rd_addr0=7, rd_en0=1.
   - Required with MEM_BYPASS_EN defined: rd_dout0=32'h0000_5678.
   - Required without it: rd_dout0=32'h0000_00FF, and a following read returns 32'h0000_5678.
5. Reset mid-sweep:
   - Stimulus: assert rst at sweep cycle 8 for one cycle, then release.
   - Required: outputs go to 0 immediately; init_busy stays high for a further full 16 cycles after release.
6. Reset in RUN:
   - Stimulus: populate addr 0..15 with nonzero values, then pulse rst.
   - Required: rd_dout0/rd_dout1 go to 0 asynchronously; after the 16-cycle sweep, every address reads 32'h0.
